// File: rtl/tc_ram_arbiter_if.sv
// Requester-side command/response bus and RAM-side port signals of tc_ram_arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters + RAM).
interface tc_ram_arbiter_if #(
    parameter int BIT_WIDTH = 16,
    parameter int NUM_REQ   = 4
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ-1:0]           we;
    logic [NUM_REQ-1:0]           lock;
    logic [NUM_REQ*16-1:0]        addr;
    logic [NUM_REQ*BIT_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]           gnt;
    logic [NUM_REQ-1:0]           rvalid;
    logic [NUM_REQ*BIT_WIDTH-1:0] rdata;

    logic                         ram_load0;
    logic                         ram_save;
    logic                         ram_load1;
    logic [15:0]                  ram_address0;
    logic [15:0]                  ram_address1;
    logic [BIT_WIDTH-1:0]         ram_in;
    logic [BIT_WIDTH-1:0]         ram_out0;
    logic [BIT_WIDTH-1:0]         ram_out1;

    modport slave (
        input  req, we, lock, addr, wdata, ram_out0, ram_out1,
        output gnt, rvalid, rdata, ram_load0, ram_save, ram_load1,
               ram_address0, ram_address1, ram_in
    );

    modport master (
        output req, we, lock, addr, wdata, ram_out0, ram_out1,
        input  gnt, rvalid, rdata, ram_load0, ram_save, ram_load1,
               ram_address0, ram_address1, ram_in
    );
endinterface

// File: rtl/tc_ram_arbiter.sv
// Round-robin arbiter sharing a dual-port RAM (port 0 R/W, port 1 read-only) between
// NUM_REQ requesters, with a per-requester lock that reserves port 0 for RMW sequences.
module tc_ram_arbiter #(
    parameter int BIT_WIDTH = 16,
    parameter int NUM_REQ   = 4
) (
    input  logic             clk,
    input  logic             rst,
    tc_ram_arbiter_if.slave  bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_ptr0, r_ptr1, r_owner;
    logic [IW-1:0]   r_src0, r_src1;
    logic            r_rv0, r_rv1;

    logic            w_p0_vld, w_p1_vld;
    logic [IW-1:0]   w_p0_idx, w_p1_idx, w_cand;

    function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] v);
        return (32'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    // Winner search; all grants are masked while reset is asserted.
    always_comb begin
        w_p0_vld = 1'b0;
        w_p0_idx = '0;
        w_p1_vld = 1'b0;
        w_p1_idx = '0;
        w_cand   = '0;
        if (rst) begin
            if (r_state == ST_LOCKED) begin
                w_p0_vld = bus.req[r_owner];
                w_p0_idx = r_owner;
            end else begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    w_cand = IW'((32'(r_ptr0) + k) % NUM_REQ);
                    if (!w_p0_vld && bus.req[w_cand]) begin
                        w_p0_vld = 1'b1;
                        w_p0_idx = w_cand;
                    end
                end
            end
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                w_cand = IW'((32'(r_ptr1) + k) % NUM_REQ);
                if (!w_p1_vld && bus.req[w_cand] && !bus.we[w_cand]
                    && !(w_p0_vld && w_cand == w_p0_idx)
                    && !(r_state == ST_LOCKED && w_cand == r_owner)) begin
                    w_p1_vld = 1'b1;
                    w_p1_idx = w_cand;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_p0_vld && bus.lock[w_p0_idx]) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (bus.req[r_owner] && !bus.lock[r_owner]) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.gnt          = '0;
        bus.ram_load0    = 1'b0;
        bus.ram_save     = 1'b0;
        bus.ram_load1    = 1'b0;
        bus.ram_address0 = '0;
        bus.ram_address1 = '0;
        bus.ram_in       = '0;
        if (w_p0_vld) begin
            bus.gnt[w_p0_idx] = 1'b1;
            bus.ram_address0  = bus.addr[w_p0_idx*16 +: 16];
            if (bus.we[w_p0_idx]) begin
                bus.ram_save = 1'b1;
                bus.ram_in   = bus.wdata[w_p0_idx*BIT_WIDTH +: BIT_WIDTH];
            end else begin
                bus.ram_load0 = 1'b1;
            end
        end
        if (w_p1_vld) begin
            bus.gnt[w_p1_idx] = 1'b1;
            bus.ram_load1     = 1'b1;
            bus.ram_address1  = bus.addr[w_p1_idx*16 +: 16];
        end
    end

    // src0 and src1 never collide when both valid: port 1 excludes the port 0 winner.
    always_comb begin
        bus.rvalid = '0;
        bus.rdata  = '0;
        if (r_rv0) begin
            bus.rvalid[r_src0]                      = 1'b1;
            bus.rdata[r_src0*BIT_WIDTH +: BIT_WIDTH] = bus.ram_out0;
        end
        if (r_rv1) begin
            bus.rvalid[r_src1]                      = 1'b1;
            bus.rdata[r_src1*BIT_WIDTH +: BIT_WIDTH] = bus.ram_out1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr0  <= '0;
            r_ptr1  <= '0;
            r_owner <= '0;
            r_src0  <= '0;
            r_src1  <= '0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_p0_vld)
                r_ptr0 <= f_inc(w_p0_idx);
            if (w_p1_vld)
                r_ptr1 <= f_inc(w_p1_idx);
            if (r_state == ST_IDLE && w_state_nxt == ST_LOCKED)
                r_owner <= w_p0_idx;
            r_rv0  <= w_p0_vld && !bus.we[w_p0_idx];
            r_src0 <= w_p0_idx;
            r_rv1  <= w_p1_vld;
            r_src1 <= w_p1_idx;
        end
    end
endmodule

// File: tb/tb_tc_ram_arbiter.sv
// Bench for tc_ram_arbiter: directed scenarios plus random traffic, all checked
// against a behavioural model of the arbitration rules and a shadow memory.
module tb_tc_ram_arbiter;
    localparam int BW = 16;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tc_ram_arbiter_if #(.BIT_WIDTH(BW), .NUM_REQ(N)) bus ();
    tc_ram_arbiter #(.BIT_WIDTH(BW), .NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    // RAM: negedge write on port 0, registered reads on both ports.
    logic [BW-1:0] ram [0:65535];
    always @(negedge clk) if (bus.ram_save) ram[bus.ram_address0] <= bus.ram_in;
    always @(posedge clk) begin
        if (bus.ram_load0) bus.ram_out0 <= ram[bus.ram_address0];
        if (bus.ram_load1) bus.ram_out1 <= ram[bus.ram_address1];
    end

    // Reference model state
    logic [BW-1:0]   m_mem [0:65535];
    int              m_ptr0, m_ptr1, m_owner;
    bit              m_locked;
    logic [N-1:0]    m_rv;
    logic [N*BW-1:0] m_rd;

    int n_chk = 0;
    int n_fail = 0;
    logic [N-1:0]    last_gnt, last_rvalid;
    logic [N*BW-1:0] last_rdata;
    logic            last_l1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] addr_of(input int i);
        return bus.addr[i*16 +: 16];
    endfunction

    task automatic model_reset();
        m_ptr0 = 0; m_ptr1 = 0; m_owner = 0; m_locked = 0;
        m_rv = '0; m_rd = '0;
    endtask

    task automatic set_cmd(input int i, input bit r, input bit w, input bit l,
                           input logic [15:0] a, input logic [BW-1:0] d);
        bus.req[i] = r; bus.we[i] = w; bus.lock[i] = l;
        bus.addr[i*16 +: 16] = a;
        bus.wdata[i*BW +: BW] = d;
    endtask

    task automatic clear_all();
        bus.req = '0; bus.we = '0; bus.lock = '0; bus.addr = '0; bus.wdata = '0;
    endtask

    // Called at posedge+1 with inputs applied; checks mid-cycle, advances the model.
    task automatic step();
        int w0, w1, j;
        logic [N-1:0] eg, nrv;
        logic [N*BW-1:0] nrd;
        logic el0, esv, el1;
        logic [15:0] ea0, ea1;
        logic [BW-1:0] ein;
        #3;
        w0 = -1; w1 = -1; eg = '0; el0 = 0; esv = 0; el1 = 0;
        ea0 = '0; ea1 = '0; ein = '0;
        if (!rst) model_reset();
        else begin
            if (m_locked) begin
                if (bus.req[m_owner]) w0 = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr0 + k) % N;
                    if (w0 < 0 && bus.req[j]) w0 = j;
                end
            end
            for (int k = 0; k < N; k++) begin
                j = (m_ptr1 + k) % N;
                if (w1 < 0 && bus.req[j] && !bus.we[j] && j != w0 && !(m_locked && j == m_owner))
                    w1 = j;
            end
            if (w0 >= 0) begin
                eg[w0] = 1'b1; ea0 = addr_of(w0);
                if (bus.we[w0]) begin esv = 1; ein = bus.wdata[w0*BW +: BW]; end
                else el0 = 1;
            end
            if (w1 >= 0) begin eg[w1] = 1'b1; el1 = 1; ea1 = addr_of(w1); end
        end
        last_gnt = bus.gnt; last_rvalid = bus.rvalid; last_rdata = bus.rdata;
        last_l1 = bus.ram_load1;
        check("gnt", 64'(bus.gnt), 64'(eg));
        check("rvalid", 64'(bus.rvalid), 64'(m_rv));
        check("rdata", 64'(bus.rdata), 64'(m_rd));
        check("ram_ctl", 64'({bus.ram_load0, bus.ram_save, bus.ram_load1}), 64'({el0, esv, el1}));
        check("ram_address0", 64'(bus.ram_address0), 64'(ea0));
        check("ram_address1", 64'(bus.ram_address1), 64'(ea1));
        check("ram_in", 64'(bus.ram_in), 64'(ein));
        if (rst) begin
            if (esv) m_mem[ea0] = ein;
            nrv = '0; nrd = '0;
            if (el0) begin nrv[w0] = 1'b1; nrd[w0*BW +: BW] = m_mem[ea0]; end
            if (el1) begin nrv[w1] = 1'b1; nrd[w1*BW +: BW] = m_mem[ea1]; end
            m_rv = nrv; m_rd = nrd;
            if (w1 >= 0) m_ptr1 = (w1 + 1) % N;
            if (!m_locked && w0 >= 0) begin
                m_ptr0 = (w0 + 1) % N;
                if (bus.lock[w0]) begin m_locked = 1; m_owner = w0; end
            end else if (m_locked && bus.req[m_owner] && !bus.lock[m_owner]) begin
                m_locked = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_cycle();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        logic [BW-1:0] v;
        for (int a = 0; a < 65536; a++) begin
            v = BW'($urandom);
            ram[a] = v; m_mem[a] = v;
        end
        bus.ram_out0 = '0; bus.ram_out1 = '0;
        model_reset();
        clear_all();
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset with every requester reading, then release
        for (int i = 0; i < N; i++) set_cmd(i, 1, 0, 0, 16'(i + 32), '0);
        step(); step();
        check("reset_gnt", 64'(last_gnt), 64'd0);
        rst = 1'b1;
        step();
        check("release_gnt", 64'(last_gnt), 64'b0011);
        check("release_load1", 64'(last_l1), 64'd1);

        // Write then read of the same address
        clear_all(); reset_cycle();
        set_cmd(0, 1, 1, 0, 16'h0010, 16'hBEEF);
        step();
        check("wr_gnt", 64'(last_gnt), 64'b0001);
        clear_all(); set_cmd(2, 1, 0, 0, 16'h0010, '0);
        step();
        check("rd_gnt", 64'(last_gnt), 64'b0100);
        clear_all();
        step();
        check("wr_rd_rvalid", 64'(last_rvalid), 64'b0100);
        check("wr_rd_data", 64'(last_rdata[2*BW +: BW]), 64'hBEEF);

        // Round-robin over continuous writes
        reset_cycle();
        for (int i = 0; i < N; i++) set_cmd(i, 1, 1, 0, 16'(i + 64), 16'(i * 4369));
        for (int c = 0; c < 8; c++) begin
            step();
            check("rr_gnt", 64'(last_gnt), 64'(1 << (c % N)));
            check("rr_load1", 64'(last_l1), 64'd0);
        end

        // Dual read from preloaded words
        clear_all();
        ram[1] = 16'h1111; m_mem[1] = 16'h1111;
        ram[2] = 16'h2222; m_mem[2] = 16'h2222;
        set_cmd(1, 1, 0, 0, 16'h0001, '0);
        set_cmd(3, 1, 0, 0, 16'h0002, '0);
        step();
        check("dual_gnt", 64'(last_gnt), 64'b1010);
        clear_all();
        step();
        check("dual_rvalid", 64'(last_rvalid), 64'b1010);
        check("dual_slice1", 64'(last_rdata[1*BW +: BW]), 64'h1111);
        check("dual_slice3", 64'(last_rdata[3*BW +: BW]), 64'h2222);

        // Lock sequence with a competing writer
        reset_cycle();
        set_cmd(1, 1, 1, 0, 16'h0009, 16'h5A5A);
        set_cmd(0, 1, 0, 1, 16'h0003, '0);
        step(); check("lock_c1", 64'(last_gnt), 64'b0001);
        set_cmd(0, 1, 1, 1, 16'h0003, 16'h1234);
        step(); check("lock_c2", 64'(last_gnt), 64'b0001);
        set_cmd(0, 1, 1, 0, 16'h0003, 16'h4321);
        step(); check("lock_c3", 64'(last_gnt), 64'b0001);
        set_cmd(0, 0, 0, 0, '0, '0);
        step(); check("lock_c4", 64'(last_gnt), 64'b0010);

        // Reset while locked with a read outstanding
        clear_all(); reset_cycle();
        set_cmd(0, 1, 0, 1, 16'h0005, '0);
        step();
        set_cmd(1, 1, 1, 0, 16'h0007, 16'hCAFE);
        #1 rst = 1'b0;
        #1;
        check("midrst_gnt", 64'(bus.gnt), 64'd0);
        check("midrst_rvalid", 64'(bus.rvalid), 64'd0);
        check("midrst_ctl", 64'({bus.ram_load0, bus.ram_save, bus.ram_load1}), 64'd0);
        model_reset();
        @(posedge clk); #1;
        step();
        rst = 1'b1;
        set_cmd(0, 0, 0, 0, '0, '0);
        step();
        check("midrst_regrant", 64'(last_gnt), 64'b0010);

        // Random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                set_cmd(i, $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 7) == 0, 16'($urandom_range(0, 15)), BW'($urandom));
            if ($urandom_range(0, 79) == 0) reset_cycle();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
